// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_types_pkg
// Brief  : Shared dcache address layout and snoop responder state encoding.
// Rev    : 1.0
// ============================================================================
package cpu_types_pkg;

    localparam int c_IDX_W = 3;
    localparam int c_TAG_W = 29 - c_IDX_W;

    typedef struct packed {
        logic [c_TAG_W-1:0] tag;
        logic [c_IDX_W-1:0] idx;
        logic               blkoff;
        logic [1:0]         bytoff;
    } dcachef_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WB0    = 3'd2,
        WB1    = 3'd3,
        UPD    = 3'd4,
        DONE   = 3'd5
    } snoop_state_t;

    // Word address inside a block, given the block number (addr[31:3]).
    function automatic logic [31:0] blk_word_addr(input logic [28:0] blk, input logic blkoff);
        return {blk, blkoff, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/snoop_tag_match.sv
`default_nettype none
// ============================================================================
// Module : snoop_tag_match
// Brief  : 2-way tag compare; way0 wins if both ways hit.
// Rev    : 1.0
// ============================================================================
module snoop_tag_match #(
    parameter int TAG_W = 26
) (
    input  logic [1:0]       i_valid,
    input  logic [1:0]       i_dirty,
    input  logic [TAG_W-1:0] i_tag0,
    input  logic [TAG_W-1:0] i_tag1,
    input  logic [TAG_W-1:0] i_tag,
    output logic [1:0]       o_hit,
    output logic             o_any_hit,
    output logic             o_hit_way,
    output logic             o_dirty
);

    always_comb begin
        o_hit[0]  = i_valid[0] & (i_tag0 == i_tag);
        o_hit[1]  = i_valid[1] & (i_tag1 == i_tag);
        o_any_hit = |o_hit;
        o_hit_way = ~o_hit[0] & o_hit[1];
        o_dirty   = o_any_hit & i_dirty[o_hit_way];
    end

endmodule
`default_nettype wire

// File: rtl/dcache_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module : dcache_snoop_responder
// Brief  : Snooped-side coherence responder: lookup, M-line write-back, MSI downgrade.
// Rev    : 1.0
// ============================================================================
module dcache_snoop_responder
    import cpu_types_pkg::*;
#(
    parameter int IDX_W = 3,
    parameter int TAG_W = 29 - IDX_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ccwait,
    input  logic             ccinv,
    input  logic [31:0]      ccsnoopaddr,
    input  logic             dwait,
    output logic             cctrans,
    output logic [31:0]      snoop_daddr,
    output logic [31:0]      snoop_dstore,
    output logic             snoop_active,
    output logic [IDX_W-1:0] frm_idx,
    input  logic [1:0]       frm_valid,
    input  logic [1:0]       frm_dirty,
    input  logic [TAG_W-1:0] frm_tag0,
    input  logic [TAG_W-1:0] frm_tag1,
    input  logic [31:0]      frm_w0_0,
    input  logic [31:0]      frm_w0_1,
    input  logic [31:0]      frm_w1_0,
    input  logic [31:0]      frm_w1_1,
    output logic             upd_en,
    output logic             upd_way,
    output logic             upd_valid,
    output logic             upd_dirty,
    input  logic             link_valid,
    input  logic [31:0]      link_addr,
    output logic             link_clr
);

    snoop_state_t r_state, w_next;

    logic [28:0] r_saddr;      // block number, addr[31:3]
    logic        r_sinv;
    logic        r_hit_way;
    logic [31:0] r_word0;
    logic [31:0] r_word1;
    logic        r_miss_entry; // first DONE cycle after a miss

    logic [1:0]  w_hit;
    logic        w_any_hit;
    logic        w_hit_way;
    logic        w_dirty;
    logic        w_link_match;
    logic        w_unused;

    assign w_unused = ^{ccsnoopaddr[2:0], link_addr[2:0], w_hit};

    snoop_tag_match #(
        .TAG_W (TAG_W)
    ) u_tag_match (
        .i_valid   (frm_valid),
        .i_dirty   (frm_dirty),
        .i_tag0    (frm_tag0),
        .i_tag1    (frm_tag1),
        .i_tag     (r_saddr[28:IDX_W]),
        .o_hit     (w_hit),
        .o_any_hit (w_any_hit),
        .o_hit_way (w_hit_way),
        .o_dirty   (w_dirty)
    );

    assign w_link_match = r_sinv & link_valid & (link_addr[31:3] == r_saddr);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_saddr      <= '0;
            r_sinv       <= 1'b0;
            r_hit_way    <= 1'b0;
            r_word0      <= '0;
            r_word1      <= '0;
            r_miss_entry <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_miss_entry <= (r_state == LOOKUP) && !w_any_hit;
            if (r_state == IDLE && ccwait) begin
                r_saddr <= ccsnoopaddr[31:3];
            end
            if (r_state == LOOKUP) begin
                r_sinv    <= ccinv;
                r_hit_way <= w_hit_way;
                r_word0   <= w_hit_way ? frm_w1_0 : frm_w0_0;
                r_word1   <= w_hit_way ? frm_w1_1 : frm_w0_1;
            end
        end
    end

    always_comb begin
        w_next       = r_state;
        cctrans      = 1'b0;
        snoop_daddr  = '0;
        snoop_dstore = '0;
        snoop_active = (r_state != IDLE);
        frm_idx      = r_saddr[IDX_W-1:0];
        upd_en       = 1'b0;
        upd_way      = 1'b0;
        upd_valid    = 1'b0;
        upd_dirty    = 1'b0;
        link_clr     = 1'b0;

        case (r_state)
            IDLE: begin
                // Present the index straight from the bus so the array read lands in LOOKUP.
                frm_idx = ccsnoopaddr[IDX_W+2:3];
                if (ccwait) w_next = LOOKUP;
            end
            LOOKUP: begin
                cctrans = w_dirty;
                if (w_dirty)        w_next = WB0;
                else if (w_any_hit) w_next = UPD;
                else                w_next = DONE;
            end
            WB0: begin
                cctrans      = 1'b1;
                snoop_daddr  = blk_word_addr(r_saddr, 1'b0);
                snoop_dstore = r_word0;
                if (!dwait) w_next = WB1;
            end
            WB1: begin
                cctrans      = 1'b1;
                snoop_daddr  = blk_word_addr(r_saddr, 1'b1);
                snoop_dstore = r_word1;
                if (!dwait) w_next = UPD;
            end
            UPD: begin
                upd_en    = 1'b1;
                upd_way   = r_hit_way;
                upd_valid = ~r_sinv;
                link_clr  = w_link_match;
                w_next    = DONE;
            end
            DONE: begin
                // The link register tracks addresses even when the block is not resident.
                link_clr = r_miss_entry & w_link_match;
                if (!ccwait) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_dcache_snoop_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_snoop_responder
// Brief  : Self-checking bench for dcache_snoop_responder against a cache-content model.
// Rev    : 1.0
// ============================================================================
module tb_dcache_snoop_responder;
    import cpu_types_pkg::*;

    localparam int c_IDX_W = cpu_types_pkg::c_IDX_W;
    localparam int c_TAG_W = cpu_types_pkg::c_TAG_W;
    localparam int c_SETS  = 1 << c_IDX_W;

    logic               CLK = 1'b0;
    logic               RST;
    logic               ccwait, ccinv, dwait;
    logic [31:0]        ccsnoopaddr;
    logic               cctrans, snoop_active;
    logic [31:0]        snoop_daddr, snoop_dstore;
    logic [c_IDX_W-1:0] frm_idx;
    logic [1:0]         frm_valid, frm_dirty;
    logic [c_TAG_W-1:0] frm_tag0, frm_tag1;
    logic [31:0]        frm_w0_0, frm_w0_1, frm_w1_0, frm_w1_1;
    logic               upd_en, upd_way, upd_valid, upd_dirty;
    logic               link_valid, link_clr;
    logic [31:0]        link_addr;

    logic [1:0]         mem_valid [c_SETS];
    logic [1:0]         mem_dirty [c_SETS];
    logic [c_TAG_W-1:0] mem_tag   [c_SETS][2];
    logic [31:0]        mem_word  [c_SETS][2][2];

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    assign frm_valid = mem_valid[frm_idx];
    assign frm_dirty = mem_dirty[frm_idx];
    assign frm_tag0  = mem_tag[frm_idx][0];
    assign frm_tag1  = mem_tag[frm_idx][1];
    assign frm_w0_0  = mem_word[frm_idx][0][0];
    assign frm_w0_1  = mem_word[frm_idx][0][1];
    assign frm_w1_0  = mem_word[frm_idx][1][0];
    assign frm_w1_1  = mem_word[frm_idx][1][1];

    dcache_snoop_responder dut (
        .CLK(CLK), .RST(RST), .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .dwait(dwait), .cctrans(cctrans), .snoop_daddr(snoop_daddr), .snoop_dstore(snoop_dstore),
        .snoop_active(snoop_active), .frm_idx(frm_idx), .frm_valid(frm_valid), .frm_dirty(frm_dirty),
        .frm_tag0(frm_tag0), .frm_tag1(frm_tag1), .frm_w0_0(frm_w0_0), .frm_w0_1(frm_w0_1),
        .frm_w1_0(frm_w1_0), .frm_w1_1(frm_w1_1), .upd_en(upd_en), .upd_way(upd_way),
        .upd_valid(upd_valid), .upd_dirty(upd_dirty), .link_valid(link_valid),
        .link_addr(link_addr), .link_clr(link_clr)
    );

    // Both ways matching the same tag is an illegal cache image.
    always @(negedge CLK)
        if (!RST) assert (!(frm_valid == 2'b11 && frm_tag0 == frm_tag1));

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_mem();
        for (int s = 0; s < c_SETS; s++) begin
            mem_valid[s] = 2'b00;
            mem_dirty[s] = 2'b00;
            for (int w = 0; w < 2; w++) begin
                mem_tag[s][w] = c_TAG_W'(s * 2 + w);
                mem_word[s][w][0] = 32'h0;
                mem_word[s][w][1] = 32'h0;
            end
        end
    endtask

    // One full snoop transaction, expectations derived from cache contents.
    task automatic run_snoop(input logic [31:0] a, input logic inv, input int h0, input int h1,
                             input int hold_done, input string name);
        dcachef_t    f;
        logic        hit, way, dirty, exp_clr;
        logic [31:0] wd [2];
        int          hold;
        f = a;
        hit = 1'b0;
        way = 1'b0;
        if (mem_valid[f.idx][0] && mem_tag[f.idx][0] == f.tag) hit = 1'b1;
        else if (mem_valid[f.idx][1] && mem_tag[f.idx][1] == f.tag) begin hit = 1'b1; way = 1'b1; end
        dirty   = hit && mem_dirty[f.idx][way];
        wd[0]   = mem_word[f.idx][way][0];
        wd[1]   = mem_word[f.idx][way][1];
        exp_clr = inv && link_valid && (link_addr[31:3] == a[31:3]);

        ccwait = 1'b1; ccsnoopaddr = a; ccinv = 1'($urandom); dwait = 1'($urandom);
        #1;
        checks++;
        if ({snoop_active, cctrans, frm_idx} !== {1'b0, 1'b0, f.idx}) begin
            errors++;
            $display("FAIL %s idle {active,cctrans,idx} got=%b exp=%b", name,
                     {snoop_active, cctrans, frm_idx}, {1'b0, 1'b0, f.idx});
        end

        tick();
        ccinv = inv; dwait = 1'($urandom);
        #1;
        checks++;
        if ({snoop_active, cctrans, upd_en, link_clr, frm_idx} !== {1'b1, dirty, 1'b0, 1'b0, f.idx}) begin
            errors++;
            $display("FAIL %s lookup {active,cctrans,upd,clr,idx} got=%b exp=%b", name,
                     {snoop_active, cctrans, upd_en, link_clr, frm_idx}, {1'b1, dirty, 1'b0, 1'b0, f.idx});
        end

        if (dirty) begin
            for (int b = 0; b < 2; b++) begin
                hold = (b == 0) ? h0 : h1;
                for (int k = 0; k <= hold; k++) begin
                    tick();
                    ccinv = 1'($urandom); dwait = (k < hold);
                    #1;
                    checks++;
                    if ({cctrans, snoop_active, upd_en, snoop_daddr, snoop_dstore} !==
                        {1'b1, 1'b1, 1'b0, a[31:3], b[0], 2'b00, wd[b]}) begin
                        errors++;
                        $display("FAIL %s wb%0d cyc%0d daddr=%h dstore=%h ct=%b upd=%b exp daddr=%h dstore=%h",
                                 name, b, k, snoop_daddr, snoop_dstore, cctrans, upd_en,
                                 {a[31:3], b[0], 2'b00}, wd[b]);
                    end
                end
            end
        end

        if (hit) begin
            tick();
            ccinv = 1'($urandom); dwait = 1'($urandom);
            #1;
            checks++;
            if ({upd_en, upd_way, upd_valid, upd_dirty, link_clr, cctrans, snoop_daddr} !==
                {1'b1, way, ~inv, 1'b0, exp_clr, 1'b0, 32'h0}) begin
                errors++;
                $display("FAIL %s upd {en,way,v,d,clr,ct} got=%b exp=%b daddr=%h", name,
                         {upd_en, upd_way, upd_valid, upd_dirty, link_clr, cctrans},
                         {1'b1, way, ~inv, 1'b0, exp_clr, 1'b0}, snoop_daddr);
            end
        end

        tick();
        ccinv = 1'($urandom);
        #1;
        checks++;
        if ({snoop_active, upd_en, cctrans, link_clr} !== {1'b1, 1'b0, 1'b0, (!hit && exp_clr)}) begin
            errors++;
            $display("FAIL %s done-entry {active,upd,ct,clr} got=%b exp=%b", name,
                     {snoop_active, upd_en, cctrans, link_clr}, {1'b1, 1'b0, 1'b0, (!hit && exp_clr)});
        end
        for (int k = 0; k < hold_done; k++) begin
            tick();
            ccinv = 1'($urandom);
            #1;
            checks++;
            if ({snoop_active, upd_en, cctrans, link_clr} !== 4'b1000) begin
                errors++;
                $display("FAIL %s done-hold{%0d} got=%b exp=1000", name, k,
                         {snoop_active, upd_en, cctrans, link_clr});
            end
        end
        ccwait = 1'b0;
        tick();
        #1;
        checks++;
        if ({snoop_active, upd_en, link_clr} !== 3'b000) begin
            errors++;
            $display("FAIL %s back-to-idle got=%b exp=000", name, {snoop_active, upd_en, link_clr});
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = 32'h0; dwait = 1'b1;
        link_valid = 1'b0; link_addr = 32'h0;
        clear_mem();
        tick(); tick();
        RST = 1'b0;
        #1;
        checks++;
        if ({cctrans, snoop_active, upd_en, upd_way, upd_valid, upd_dirty, link_clr, frm_idx,
             snoop_daddr, snoop_dstore} !== '0) begin
            errors++;
            $display("FAIL reset outputs ct=%b act=%b upd=%b clr=%b daddr=%h dstore=%h exp all zero",
                     cctrans, snoop_active, upd_en, link_clr, snoop_daddr, snoop_dstore);
        end
    endtask

    task automatic test_read_dirty();
        clear_mem();
        mem_valid[2] = 2'b11; mem_dirty[2] = 2'b10;
        mem_tag[2][0] = 26'h0123456; mem_tag[2][1] = 26'h2ABCDEF;
        mem_word[2][1][0] = 32'hAAAA0000; mem_word[2][1][1] = 32'hBBBB1111;
        link_valid = 1'b0;
        run_snoop({26'h2ABCDEF, 3'd2, 3'b000}, 1'b0, 1, 2, 1, "read_dirty");
    endtask

    task automatic test_inv_clean_link();
        clear_mem();
        mem_valid[5] = 2'b01; mem_dirty[5] = 2'b00; mem_tag[5][0] = 26'h1555555;
        link_valid = 1'b1; link_addr = {26'h1555555, 3'd5, 3'b100};
        run_snoop({26'h1555555, 3'd5, 3'b000}, 1'b1, 0, 0, 0, "inv_clean_link");
    endtask

    task automatic test_miss();
        clear_mem();
        link_valid = 1'b1; link_addr = 32'h0000_0F00;
        run_snoop(32'h1234_5678, 1'b0, 0, 0, 3, "miss_read");
        link_addr = 32'h1234_567C;
        run_snoop(32'h1234_5678, 1'b1, 0, 0, 2, "miss_inv_link");
    endtask

    task automatic test_dwait_stall();
        clear_mem();
        mem_valid[7] = 2'b01; mem_dirty[7] = 2'b01; mem_tag[7][0] = 26'h0C0FFEE;
        mem_word[7][0][0] = 32'hDEAD_BEEF; mem_word[7][0][1] = 32'hCAFE_F00D;
        link_valid = 1'b1; link_addr = {26'h0C0FFEE, 3'd7, 3'b000};
        run_snoop({26'h0C0FFEE, 3'd7, 3'b000}, 1'b1, 5, 3, 0, "dwait_stall");
    endtask

    task automatic test_reset_mid_wb();
        clear_mem();
        mem_valid[1] = 2'b10; mem_dirty[1] = 2'b10; mem_tag[1][1] = 26'h0000ABC;
        mem_word[1][1][0] = 32'h1111_2222; mem_word[1][1][1] = 32'h3333_4444;
        link_valid = 1'b1; link_addr = {26'h0000ABC, 3'd1, 3'b000};
        ccwait = 1'b1; ccsnoopaddr = {26'h0000ABC, 3'd1, 3'b000}; ccinv = 1'b1; dwait = 1'b0;
        tick();
        tick();
        tick();
        dwait = 1'b1;
        #1;
        checks++;
        if ({cctrans, snoop_daddr, snoop_dstore} !== {1'b1, 26'h0000ABC, 3'd1, 3'b100, 32'h3333_4444}) begin
            errors++;
            $display("FAIL rst_wb pre-reset ct=%b daddr=%h dstore=%h", cctrans, snoop_daddr, snoop_dstore);
        end
        RST = 1'b1; ccwait = 1'b0; ccsnoopaddr = 32'h0;
        tick();
        RST = 1'b0; dwait = 1'b0;
        #1;
        checks++;
        if ({cctrans, snoop_active, upd_en, link_clr, snoop_daddr, snoop_dstore} !== '0) begin
            errors++;
            $display("FAIL rst_wb after-reset ct=%b act=%b upd=%b clr=%b daddr=%h dstore=%h exp zero",
                     cctrans, snoop_active, upd_en, link_clr, snoop_daddr, snoop_dstore);
        end
        tick();
        #1;
        checks++;
        if ({snoop_active, upd_en, link_clr} !== 3'b000) begin
            errors++;
            $display("FAIL rst_wb settle got=%b exp=000", {snoop_active, upd_en, link_clr});
        end
    endtask

    task automatic test_ccinv_idle();
        link_valid = 1'b1; link_addr = 32'h0000_0040;
        ccwait = 1'b0; ccsnoopaddr = 32'h0000_0040;
        for (int k = 0; k < 4; k++) begin
            ccinv = 1'b1; dwait = 1'($urandom);
            tick();
            checks++;
            if ({snoop_active, link_clr, upd_en, cctrans} !== 4'b0000) begin
                errors++;
                $display("FAIL ccinv_idle cyc%0d got=%b exp=0000", k, {snoop_active, link_clr, upd_en, cctrans});
            end
        end
        ccinv = 1'b0;
    endtask

    task automatic test_random();
        int          s, kind;
        logic [31:0] a;
        logic        inv;
        for (int n = 0; n < 40; n++) begin
            clear_mem();
            s = $urandom_range(0, c_SETS - 1);
            mem_valid[s]  = 2'($urandom);
            mem_dirty[s]  = 2'($urandom);
            mem_tag[s][0] = c_TAG_W'($urandom);
            mem_tag[s][1] = mem_tag[s][0] + c_TAG_W'($urandom_range(1, 1000));
            for (int w = 0; w < 2; w++)
                for (int b = 0; b < 2; b++) mem_word[s][w][b] = $urandom;
            kind = $urandom_range(0, 2);
            a = {(kind == 2) ? c_TAG_W'($urandom) : mem_tag[s][kind], 3'(s), 3'($urandom)};
            inv = 1'($urandom);
            link_valid = 1'($urandom);
            link_addr = ($urandom_range(0, 1) == 1) ? {a[31:3], 3'($urandom)} : $urandom;
            run_snoop(a, inv, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_read_dirty();
        test_inv_clean_link();
        test_miss();
        test_dwait_stall();
        test_reset_mid_wb();
        test_ccinv_idle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
